// File: rtl/bar_graph_peak.sv
// Bar-graph renderer with per-bar peak-hold markers. Heights are staged in a shadow
// bank, committed one bar per cycle after frame_tick, and pixels are classified with one cycle latency.
module bar_graph_peak #(
    parameter int unsigned N_BARS      = 16,
    parameter int unsigned X0          = 2,
    parameter int unsigned PITCH       = 40,
    parameter int unsigned BAR_W       = 36,
    parameter int unsigned Y_BASE      = 480,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned DECAY_STEP  = 4,
    parameter int unsigned PEAK_H      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      load_valid,
    input  logic [$clog2(N_BARS)-1:0] load_idx,
    input  logic [8:0]                load_height,
    output logic                      load_ready,
    input  logic [9:0]                xin,
    input  logic [8:0]                yin,
    output logic                      bar_on,
    output logic                      peak_on,
    output logic [$clog2(N_BARS)-1:0] bar_idx,
    output logic                      overrun
);

    localparam int unsigned IdxW  = $clog2(N_BARS);
    localparam int unsigned HoldW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    localparam logic [8:0]       YMax     = 9'(Y_BASE);
    localparam logic [8:0]       DecStep  = 9'(DECAY_STEP);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_FRAMES);
    localparam logic [10:0]      YBase    = 11'(Y_BASE);
    localparam logic [10:0]      PeakH    = 11'(PEAK_H);
    localparam logic [10:0]      BarW     = 11'(BAR_W);

    typedef enum logic [0:0] {StIdle, StCommit} state_e;

    state_e state_q, state_d;
    logic [IdxW-1:0] cnt_q, cnt_d;
    logic overrun_q, overrun_d;

    logic [8:0]       shadow_q  [N_BARS];
    logic [8:0]       display_q [N_BARS];
    logic [8:0]       peak_q    [N_BARS];
    logic [HoldW-1:0] hold_q    [N_BARS];

    logic            bar_on_q, peak_on_q;
    logic [IdxW-1:0] bar_idx_q;

    logic            load_fire;
    logic [8:0]      load_clamped;
    logic [8:0]      cur_sh, cur_pk, pk_dec, new_peak;
    logic [HoldW-1:0] cur_hd, new_hold;

    logic            pix_bar_d, pix_peak_d;
    logic [IdxW-1:0] pix_idx_d;
    logic [10:0]     x_ext, y_ext, x_left, y_top, p_top;

    assign load_fire    = load_valid && load_ready && (32'(load_idx) < N_BARS);
    assign load_clamped = (load_height > YMax) ? YMax : load_height;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        load_ready = 1'b0;
        case (state_q)
            StIdle: begin
                load_ready = !frame_tick;
                if (frame_tick) begin
                    state_d = StCommit;
                    cnt_d   = '0;
                end
            end
            StCommit: begin
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == IdxW'(N_BARS - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Peak/hold update for the bar visited this cycle; decay saturates at zero.
    always_comb begin
        cur_sh   = shadow_q[cnt_q];
        cur_pk   = peak_q[cnt_q];
        cur_hd   = hold_q[cnt_q];
        pk_dec   = (cur_pk > DecStep) ? (cur_pk - DecStep) : '0;
        new_peak = cur_pk;
        new_hold = cur_hd;
        if (cur_sh >= cur_pk) begin
            new_peak = cur_sh;
            new_hold = HoldInit;
        end else if (cur_hd != '0) begin
            new_hold = cur_hd - 1'b1;
        end else begin
            new_peak = (pk_dec > cur_sh) ? pk_dec : cur_sh;
        end
    end

    assign x_ext = {1'b0, xin};
    assign y_ext = {2'b0, yin};

    always_comb begin
        pix_bar_d  = 1'b0;
        pix_peak_d = 1'b0;
        pix_idx_d  = '0;
        x_left     = '0;
        y_top      = '0;
        p_top      = '0;
        for (int j = 0; j < N_BARS; j++) begin
            x_left = 11'(X0 + j * PITCH);
            if (x_ext >= x_left && x_ext < x_left + BarW) begin
                pix_idx_d  = IdxW'(j);
                y_top      = YBase - {2'b0, display_q[j]};
                p_top      = YBase - {2'b0, peak_q[j]};
                pix_bar_d  = (display_q[j] != '0) && (y_ext >= y_top) && (y_ext < YBase);
                pix_peak_d = (peak_q[j] != '0) && (y_ext >= p_top) && (y_ext < p_top + PeakH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            bar_on_q  <= 1'b0;
            peak_on_q <= 1'b0;
            bar_idx_q <= '0;
            for (int i = 0; i < N_BARS; i++) begin
                shadow_q[i]  <= '0;
                display_q[i] <= '0;
                peak_q[i]    <= '0;
                hold_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            bar_on_q  <= pix_bar_d;
            peak_on_q <= pix_peak_d;
            bar_idx_q <= pix_idx_d;
            if (load_fire) begin
                shadow_q[load_idx] <= load_clamped;
            end
            if (state_q == StCommit) begin
                display_q[cnt_q] <= cur_sh;
                peak_q[cnt_q]    <= new_peak;
                hold_q[cnt_q]    <= new_hold;
            end
        end
    end

    assign bar_on  = bar_on_q;
    assign peak_on = peak_on_q;
    assign bar_idx = bar_idx_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_bar_graph_peak.sv
// Directed bench for bar_graph_peak; 12 bars so that an out-of-range load_idx fits the port.
module tb_bar_graph_peak;

    localparam int NB = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_idx = '0;
    logic [8:0] load_height = '0;
    logic       load_ready;
    logic [9:0] xin = '0;
    logic [8:0] yin = '0;
    logic       bar_on, peak_on, overrun;
    logic [3:0] bar_idx;

    int checks = 0;
    int errors = 0;

    bar_graph_peak #(.N_BARS(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .load_valid (load_valid),
        .load_idx   (load_idx),
        .load_height(load_height),
        .load_ready (load_ready),
        .xin        (xin),
        .yin        (yin),
        .bar_on     (bar_on),
        .peak_on    (peak_on),
        .bar_idx    (bar_idx),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int h);
        load_valid  = 1'b1;
        load_idx    = 4'(idx);
        load_height = 9'(h);
        tick();
        load_valid  = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (NB) tick();
    endtask

    task automatic pix(input int x, input int y);
        xin = 10'(x);
        yin = 9'(y);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", load_ready); end
        if (bar_on !== 1'b0) begin errors++; $display("FAIL reset_bar_on got %b exp 0", bar_on); end
        if (peak_on !== 1'b0) begin errors++; $display("FAIL reset_peak_on got %b exp 0", peak_on); end
        if (bar_idx !== 4'd0) begin errors++; $display("FAIL reset_bar_idx got %0d exp 0", bar_idx); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_basic();
        load(3, 100);
        frame();
        pix(122, 379);
        checks += 2;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL basic_379_bar got %b exp 0", bar_on); end
        if (bar_idx !== 4'd3) begin errors++; $display("FAIL basic_379_idx got %0d exp 3", bar_idx); end
        xin = 10'd122;
        yin = 9'd380;
        #1;
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL basic_latency got %b exp 0", bar_on); end
        tick();
        checks += 3;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL basic_380_bar got %b exp 1", bar_on); end
        if (bar_idx !== 4'd3) begin errors++; $display("FAIL basic_380_idx got %0d exp 3", bar_idx); end
        if (peak_on !== 1'b1) begin errors++; $display("FAIL basic_380_peak got %b exp 1", peak_on); end
        pix(122, 382);
        checks++;
        if (peak_on !== 1'b1) begin errors++; $display("FAIL basic_382_peak got %b exp 1", peak_on); end
        pix(122, 383);
        checks += 2;
        if (peak_on !== 1'b0) begin errors++; $display("FAIL basic_383_peak got %b exp 0", peak_on); end
        if (bar_on !== 1'b1) begin errors++; $display("FAIL basic_383_bar got %b exp 1", bar_on); end
    endtask

    task automatic test_clamp();
        load(0, 500);
        frame();
        pix(2, 0);
        checks += 3;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL clamp_bar got %b exp 1", bar_on); end
        if (peak_on !== 1'b1) begin errors++; $display("FAIL clamp_peak got %b exp 1", peak_on); end
        if (bar_idx !== 4'd0) begin errors++; $display("FAIL clamp_idx got %0d exp 0", bar_idx); end
        pix(37, 0);
        checks++;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL clamp_edge_bar got %b exp 1", bar_on); end
        pix(122, 0);
        checks++;
        if (bar_idx !== 4'd3) begin errors++; $display("FAIL clamp_pre_gap_idx got %0d exp 3", bar_idx); end
        pix(38, 0);
        checks += 3;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL gap_bar got %b exp 0", bar_on); end
        if (peak_on !== 1'b0) begin errors++; $display("FAIL gap_peak got %b exp 0", peak_on); end
        if (bar_idx !== 4'd0) begin errors++; $display("FAIL gap_idx got %0d exp 0", bar_idx); end
    endtask

    task automatic test_decay();
        int p;
        do_reset();
        load(0, 200);
        frame();
        pix(2, 280);
        checks += 2;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL decay_init_bar got %b exp 1", bar_on); end
        if (peak_on !== 1'b1) begin errors++; $display("FAIL decay_init_peak got %b exp 1", peak_on); end
        pix(2, 279);
        checks++;
        if (peak_on !== 1'b0) begin errors++; $display("FAIL decay_init_279 got %b exp 0", peak_on); end
        load(0, 0);
        for (int k = 1; k <= 30; k++) begin
            frame();
            pix(2, 280);
            checks++;
            if (peak_on !== 1'b1) begin
                errors++;
                $display("FAIL hold_frame_%0d got %b exp 1", k, peak_on);
            end
        end
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL decay_bar_zero got %b exp 0", bar_on); end
        for (int m = 1; m <= 50; m++) begin
            frame();
            p = 200 - 4 * m;
            if (p > 0) begin
                pix(2, 480 - p);
                checks++;
                if (peak_on !== 1'b1) begin
                    errors++;
                    $display("FAIL decay_%0d_top got %b exp 1", p, peak_on);
                end
                pix(2, 479 - p);
                checks++;
                if (peak_on !== 1'b0) begin
                    errors++;
                    $display("FAIL decay_%0d_above got %b exp 0", p, peak_on);
                end
            end else begin
                pix(2, 479);
                checks++;
                if (peak_on !== 1'b0) begin
                    errors++;
                    $display("FAIL decay_zero got %b exp 0", peak_on);
                end
            end
        end
        frame();
        frame();
        load(0, 10);
        frame();
        pix(2, 470);
        checks += 2;
        if (peak_on !== 1'b1) begin errors++; $display("FAIL nowrap_peak got %b exp 1", peak_on); end
        if (bar_on !== 1'b1) begin errors++; $display("FAIL nowrap_bar got %b exp 1", bar_on); end
    endtask

    task automatic test_overrun();
        load(4, 50);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks += 2;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL ovr_ready_start got %b exp 0", load_ready); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
        repeat (4) tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
        for (int e = 7; e <= 12; e++) begin
            tick();
            checks++;
            if (load_ready !== 1'b0) begin
                errors++;
                $display("FAIL ovr_ready_edge%0d got %b exp 0", e, load_ready);
            end
        end
        tick();
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready_end got %b exp 1", load_ready); end
        pix(162, 430);
        checks++;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL ovr_commit_430 got %b exp 1", bar_on); end
        pix(162, 429);
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL ovr_commit_429 got %b exp 0", bar_on); end
    endtask

    task automatic test_load_ignore();
        frame_tick  = 1'b1;
        load_valid  = 1'b1;
        load_idx    = 4'd4;
        load_height = 9'd300;
        tick();
        frame_tick = 1'b0;
        repeat (5) tick();
        load_valid = 1'b0;
        repeat (NB - 5) tick();
        load(NB, 300);
        frame();
        pix(162, 430);
        checks++;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL ignore_b4_430 got %b exp 1", bar_on); end
        pix(162, 429);
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL ignore_b4_429 got %b exp 0", bar_on); end
        pix(2, 469);
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL ignore_b0_469 got %b exp 0", bar_on); end
    endtask

    task automatic test_reset_mid();
        load(2, 60);
        frame();
        pix(82, 420);
        checks += 2;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL mid_pre_bar got %b exp 1", bar_on); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL mid_sticky got %b exp 1", overrun); end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (6) tick();
        do_reset();
        checks += 5;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", load_ready); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b exp 0", overrun); end
        if (bar_on !== 1'b0) begin errors++; $display("FAIL mid_bar got %b exp 0", bar_on); end
        if (peak_on !== 1'b0) begin errors++; $display("FAIL mid_peak got %b exp 0", peak_on); end
        if (bar_idx !== 4'd0) begin errors++; $display("FAIL mid_idx got %0d exp 0", bar_idx); end
        pix(82, 479);
        checks += 3;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL mid_dark_bar got %b exp 0", bar_on); end
        if (peak_on !== 1'b0) begin errors++; $display("FAIL mid_dark_peak got %b exp 0", peak_on); end
        if (bar_idx !== 4'd2) begin errors++; $display("FAIL mid_dark_idx got %0d exp 2", bar_idx); end
        pix(2, 479);
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL mid_dark_b0 got %b exp 0", bar_on); end
        load(2, 20);
        frame();
        pix(82, 460);
        checks++;
        if (bar_on !== 1'b1) begin errors++; $display("FAIL mid_after_460 got %b exp 1", bar_on); end
        pix(82, 459);
        checks++;
        if (bar_on !== 1'b0) begin errors++; $display("FAIL mid_after_459 got %b exp 0", bar_on); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_decay();
        test_overrun();
        test_load_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bar_graph_peak.md
BAR_GRAPH_PEAK -- requirements
Module: bar_graph_peak

Interface
REQ-001 SHALL have parameter N_BARS, default 16, number of bars (2..32).
REQ-002 SHALL have parameter X0, default 2, left x of bar 0.
REQ-003 SHALL have parameter PITCH, default 40, x distance between left edges of adjacent bars.
REQ-004 SHALL have parameter BAR_W, default 36, bar width in pixels (BAR_W < PITCH).
REQ-005 SHALL have parameter Y_BASE, default 480, bottom edge y (exclusive) of all bars.
REQ-006 SHALL have parameter HOLD_FRAMES, default 30, frames a new peak is held before decay.
REQ-007 SHALL have parameter DECAY_STEP, default 4, peak decrease per frame after hold.
REQ-008 SHALL have parameter PEAK_H, default 3, peak marker thickness in pixels.
REQ-009 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-010 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-011 SHALL have port frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-012 SHALL have port load_valid  in  1  new height offered.
REQ-013 SHALL have port load_idx  in  $clog2(N_BARS)  target bar.
REQ-014 SHALL have port load_height  in  9  new height, pixels.
REQ-015 SHALL have port load_ready  out  1  load accepted when valid and ready both high.
REQ-016 SHALL have ports xin  in  10 and yin  in  9, current pixel coordinate.
REQ-017 SHALL have ports bar_on  out  1, peak_on  out  1 and bar_idx  out  $clog2(N_BARS), pixel classification.
REQ-018 SHALL have port overrun  out  1  sticky flag: frame_tick arrived during COMMIT.

Function
REQ-019 SHALL keep per bar a shadow height, a display height, a peak and a hold counter.
REQ-020 SHALL write load_height, clamped to Y_BASE, into shadow[load_idx] on a handshake; load_idx >= N_BARS is dropped.
REQ-021 SHALL use FSM states IDLE and COMMIT; IDLE -> COMMIT on frame_tick; COMMIT visits bars 0..N_BARS-1, one per cycle, then returns to IDLE.
REQ-022 SHALL drive load_ready high only in IDLE and not in the cycle frame_tick is sampled; load_valid outside ready is ignored.
REQ-023 SHALL, for visited bar j: display[j] <= shadow[j]; if shadow[j] >= peak[j], peak <= shadow, hold <= HOLD_FRAMES.
REQ-024 SHALL otherwise, if hold > 0, decrement hold; else peak <= max(peak - DECAY_STEP, shadow), saturating at 0, no wrap.
REQ-025 SHALL ignore frame_tick during COMMIT and set overrun, which clears only on reset.
REQ-026 SHALL treat bar j as covering X0+j*PITCH <= xin < X0+j*PITCH+BAR_W; gaps and x beyond the last bar match no bar.
REQ-027 SHALL assert bar_on when xin is in bar j and yin >= Y_BASE - display[j]; height 0 gives no pixels.
REQ-028 SHALL assert peak_on when xin is in bar j, peak[j] > 0 and Y_BASE - peak[j] <= yin < Y_BASE - peak[j] + PEAK_H.
REQ-029 SHALL drive bar_on and peak_on both high when both conditions hold.
REQ-030 SHALL register bar_on, peak_on and bar_idx with exactly one cycle latency from xin/yin.
REQ-031 SHALL drive bar_idx to the matched j, and to 0 when no bar matches.

Reset
REQ-032 SHALL, on reset, clear all shadow, display, peak and hold values, enter IDLE, set load_ready=1, and drive bar_on=0, peak_on=0, bar_idx=0, overrun=0 on the next edge.
REQ-033 SHALL let reset mid-COMMIT abort the sweep immediately, with no partial state retained.

Verification
REQ-034 SHALL test: load bar 3 = 100, frame_tick, wait N_BARS cycles, xin=122, yin=380 -> bar_on=1, bar_idx=3 one cycle later; yin=379 -> bar_on=0.
REQ-035 SHALL test: bar 0 = 200 then = 0 on the next frame -> peak holds 200 for 30 frames, then reads 196, 192, ... down to 0, never wrapping.
REQ-036 SHALL test: load_height = 500 -> clamped to 480; with xin=2, yin=0, bar_on=1; xin=38 (gap) -> bar_on=0, bar_idx=0.
REQ-037 SHALL test: frame_tick pulsed 5 cycles after the prior tick -> overrun=1, sweep unaffected, load_ready=0 until the sweep ends.
REQ-038 SHALL test: reset at sweep cycle 7 -> next cycle IDLE, load_ready=1, all bars dark, overrun=0.
REQ-039 SHALL test: load_valid with load_ready=0 -> shadow unchanged; load_idx=N_BARS -> dropped.
